// File: rtl/input_feed_sequencer_if.sv
// input_feed_sequencer_if: buffer read port, MUX-stage handshake and pass control bundle
interface input_feed_sequencer_if #(parameter int ADDR_WIDTH = 8);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   num_words;
    logic [1:0]            weight_bitwidth;
    logic                  buf_rd_en;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    logic [31:0]           buf_rd_data;
    logic [31:0]           buffer;
    logic [1:0]            state;
    logic                  valid;
    logic                  ready;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, base_addr, num_words, weight_bitwidth, buf_rd_data, ready,
        output buf_rd_en, buf_rd_addr, buffer, state, valid, busy, done
    );
    modport slave (
        output start, base_addr, num_words, weight_bitwidth, buf_rd_data, ready,
        input  buf_rd_en, buf_rd_addr, buffer, state, valid, busy, done
    );
endinterface

// File: rtl/input_feed_sequencer.sv
// input_feed_sequencer: fetches buffer words and replays each for P weight phases to the MUX stage
module input_feed_sequencer #(
    parameter int ADDR_WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    input_feed_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} fsm_t;

    fsm_t                  r_fsm;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_num;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [1:0]            r_wbw;
    logic [1:0]            r_ph;
    logic [31:0]           r_buffer;
    logic                  r_rd_en;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            w_last_ph;
    logic [ADDR_WIDTH:0]   w_idx_next;

    assign w_last_ph  = (r_wbw == 2'b00) ? 2'd0 : (r_wbw == 2'b01) ? 2'd1 : 2'd3;
    assign w_idx_next = r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};

    assign bus.buf_rd_en   = r_rd_en;
    assign bus.buf_rd_addr = r_addr;
    assign bus.buffer      = r_buffer;
    assign bus.state       = r_ph;
    assign bus.valid       = r_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    // Pass sequencer: every output is a register updated on the same edge as the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm    <= IDLE;
            r_base   <= '0;
            r_addr   <= '0;
            r_num    <= '0;
            r_idx    <= '0;
            r_wbw    <= '0;
            r_ph     <= '0;
            r_buffer <= '0;
            r_rd_en  <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: if (bus.start) begin
                    r_base <= bus.base_addr;
                    r_num  <= bus.num_words;
                    r_wbw  <= bus.weight_bitwidth;
                    r_idx  <= '0;
                    r_ph   <= '0;
                    r_busy <= 1'b1;
                    if (bus.num_words != '0) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= bus.base_addr;
                        r_fsm   <= FETCH;
                    end else begin
                        r_done <= 1'b1;
                        r_fsm  <= DONE;
                    end
                end
                FETCH: begin
                    r_rd_en <= 1'b0;
                    r_fsm   <= WAIT;
                end
                WAIT: begin
                    r_buffer <= bus.buf_rd_data;
                    r_ph     <= '0;
                    r_valid  <= 1'b1;
                    r_fsm    <= EMIT;
                end
                EMIT: if (bus.ready) begin
                    if (r_ph != w_last_ph) begin
                        r_ph <= r_ph + 2'd1;
                    end else if (w_idx_next == r_num) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_fsm   <= DONE;
                    end else begin
                        r_valid <= 1'b0;
                        r_idx   <= w_idx_next;
                        r_rd_en <= 1'b1;
                        r_addr  <= r_base + w_idx_next[ADDR_WIDTH-1:0];
                        r_fsm   <= FETCH;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_fsm  <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_feed_sequencer.sv
// tb_input_feed_sequencer: directed passes with a queue scoreboard checked by a negedge monitor
module tb_input_feed_sequencer;
    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
        int          c;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [31:0] mem [256];
    beat_t exp_beats[$];
    logic [7:0] exp_reads[$];
    int exp_done[$];

    input_feed_sequencer_if #(.ADDR_WIDTH(8)) bus ();
    input_feed_sequencer #(.ADDR_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] s, input int c);
        beat_t b;
        b.d = d;
        b.s = s;
        b.c = c;
        exp_beats.push_back(b);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, an accepted pair or done
    always @(negedge clk) begin
        if (bus.buf_rd_en) begin
            if (exp_reads.size() == 0) chk("unexpected_read", {24'h0, bus.buf_rd_addr}, 32'hFFFF_FFFF);
            else chk("rd_addr", {24'h0, bus.buf_rd_addr}, {24'h0, exp_reads.pop_front()});
        end
        if (bus.valid && bus.ready) begin
            if (exp_beats.size() == 0) chk("unexpected_beat", bus.buffer, 32'hFFFF_FFFF);
            else begin
                beat_t b;
                b = exp_beats.pop_front();
                chk("buffer", bus.buffer, b.d);
                chk("state", {30'h0, bus.state}, {30'h0, b.s});
                if (b.c >= 0) chk("beat_cycle", cyc, b.c);
            end
        end
        if (bus.done) begin
            if (exp_done.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
            else chk("done_cycle", cyc, exp_done.pop_front());
        end
    end

    task automatic do_start(input logic [7:0] base, input logic [8:0] num, input logic [1:0] wbw,
                            input int p, output int e);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.num_words = num;
        bus.weight_bitwidth = wbw;
        e = cyc + 1;
        exp_done.push_back(e + int'(num) * (p + 2));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy && n < 200);
        chk("idle_timeout", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_buffer"}, bus.buffer, 32'h0);
        chk({tag, "_state"}, {30'h0, bus.state}, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.valid}, 32'h0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, bus.done}, 32'h0);
        chk({tag, "_rd_en"}, {31'h0, bus.buf_rd_en}, 32'h0);
        chk({tag, "_rd_addr"}, {24'h0, bus.buf_rd_addr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        logic [31:0] hold_buf;
        logic [1:0] hold_st;
        foreach (mem[i]) mem[i] = 32'h0;
        mem[8'h10] = 32'hA5A5_0001;
        mem[8'h11] = 32'h5A5A_0002;
        mem[8'h20] = 32'h1234_5678;
        mem[8'h30] = 32'h0303_0303;
        mem[8'h31] = 32'h3131_3131;
        mem[8'hFF] = 32'hDEAD_00FF;
        mem[8'h00] = 32'hBEEF_0000;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.weight_bitwidth = '0;
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // 8-bit, two words
        do_start(8'h10, 9'd2, 2'b00, 1, e);
        exp_reads.push_back(8'h10);
        exp_reads.push_back(8'h11);
        beat(32'hA5A5_0001, 2'd0, e + 2);
        beat(32'h5A5A_0002, 2'd0, e + 5);
        wait_idle();

        // 4-bit, one word
        do_start(8'h10, 9'd1, 2'b01, 2, e);
        exp_reads.push_back(8'h10);
        beat(32'hA5A5_0001, 2'd0, e + 2);
        beat(32'hA5A5_0001, 2'd1, e + 3);
        wait_idle();

        // 2-bit with a 3-cycle stall on phase 2
        do_start(8'h20, 9'd1, 2'b10, 2, e);
        exp_done[exp_done.size() - 1] = e + 9;
        exp_reads.push_back(8'h20);
        for (int p = 0; p < 4; p++) beat(32'h1234_5678, p[1:0], -1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(bus.valid && bus.state == 2'd2) && n < 50);
        chk("stall_reach", {31'h0, bus.valid}, 32'h1);
        bus.ready = 1'b0;
        hold_buf = bus.buffer;
        hold_st = bus.state;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_buffer", bus.buffer, hold_buf);
            chk("stall_state", {30'h0, bus.state}, {30'h0, hold_st});
            chk("stall_valid", {31'h0, bus.valid}, 32'h1);
            chk("stall_rd_en", {31'h0, bus.buf_rd_en}, 32'h0);
        end
        bus.ready = 1'b1;
        wait_idle();

        // address wrap
        do_start(8'hFF, 9'd2, 2'b00, 1, e);
        exp_reads.push_back(8'hFF);
        exp_reads.push_back(8'h00);
        beat(32'hDEAD_00FF, 2'd0, e + 2);
        beat(32'hBEEF_0000, 2'd0, e + 5);
        wait_idle();

        // zero-length pass: done only
        do_start(8'h10, 9'd0, 2'b00, 1, e);
        wait_idle();

        // start and input changes mid-pass are ignored
        do_start(8'h30, 9'd2, 2'b01, 2, e);
        exp_reads.push_back(8'h30);
        exp_reads.push_back(8'h31);
        beat(32'h0303_0303, 2'd0, e + 2);
        beat(32'h0303_0303, 2'd1, e + 3);
        beat(32'h3131_3131, 2'd0, e + 6);
        beat(32'h3131_3131, 2'd1, e + 7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.base_addr = 8'h40;
            bus.num_words = 9'd5;
            bus.weight_bitwidth = i[1:0];
        end
        bus.start = 1'b0;
        wait_idle();

        // reset during EMIT aborts with no done
        do_start(8'h10, 9'd2, 2'b10, 2, e);
        void'(exp_done.pop_back());
        exp_reads.push_back(8'h10);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.valid && n < 50);
        chk("emit_reach", {31'h0, bus.valid}, 32'h1);
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // fresh pass after reset
        do_start(8'h11, 9'd1, 2'b00, 1, e);
        exp_reads.push_back(8'h11);
        beat(32'h5A5A_0002, 2'd0, e + 2);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        chk("reads_left", exp_reads.size(), 32'h0);
        chk("beats_left", exp_beats.size(), 32'h0);
        chk("done_left", exp_done.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
